// File: rtl/fifo_traffic_gen.sv
// Drives a programmed burst of counting-pattern writes into a small FIFO and reads them back in order.
// Request outputs are combinational and gated by the full/empty flags. The compare runs 1 cycle after each accepted read.
module fifo_traffic_gen #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              full,
  input  logic              empty,
  input  logic [DATA_W-1:0] read_data,
  output logic              write_en,
  output logic [DATA_W-1:0] write_data,
  output logic              read_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  mismatch_count
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, STREAM, ALT_W, ALT_R, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  rd_issued;
  logic [DATA_W-1:0] wr_seq;
  logic [DATA_W-1:0] exp_seq;
  logic              rd_pend;
  logic              wr_phase;
  logic              rd_phase;

  assign wr_phase   = (state == WRITE) || (state == STREAM) || (state == ALT_W);
  assign rd_phase   = (state == READ)  || (state == STREAM) || (state == ALT_R);
  assign write_en   = wr_phase && !full  && (wr_count  != len);
  assign read_en    = rd_phase && !empty && (rd_issued != len);
  assign write_data = wr_seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      len            <= '0;
      rd_issued      <= '0;
      wr_seq         <= '0;
      exp_seq        <= '0;
      rd_pend        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      wr_count       <= '0;
      rd_count       <= '0;
      mismatch_count <= '0;
    end else begin
      done    <= 1'b0;
      rd_pend <= read_en;
      if (write_en) begin
        wr_count <= wr_count + 1'b1;
        wr_seq   <= wr_seq + 1'b1;
      end
      if (read_en) rd_issued <= rd_issued + 1'b1;
      // Returned word lands one cycle after the accepted read.
      if (rd_pend) begin
        exp_seq  <= exp_seq + 1'b1;
        rd_count <= rd_count + 1'b1;
        if (read_data != exp_seq) begin
          err <= 1'b1;
          if (mismatch_count != '1) mismatch_count <= mismatch_count + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            len            <= burst_len;
            wr_count       <= '0;
            rd_count       <= '0;
            rd_issued      <= '0;
            wr_seq         <= '0;
            exp_seq        <= '0;
            err            <= 1'b0;
            mismatch_count <= '0;
            if (burst_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              busy <= 1'b1;
              case (mode)
                2'd1:    state <= STREAM;
                2'd2:    state <= ALT_W;
                default: state <= WRITE;
              endcase
            end
          end
        end
        WRITE: if (wr_count == len) state <= READ;
        READ: begin
          if (rd_count == len) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        STREAM: begin
          if ((wr_count == len) && (rd_count == len)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        // Once every word is written, fall through to ALT_R to wait out the last compare.
        ALT_W: if (write_en || (wr_count == len)) state <= ALT_R;
        ALT_R: begin
          if (rd_count == len) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (read_en) begin
            state <= ALT_W;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Bench for fifo_traffic_gen: a 4-deep FIFO model with flag forcing and data corruption, plus a run-level reference model.
module tb_fifo_traffic_gen;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [CNT_W-1:0]  burst_len = '0;
  logic              full, empty;
  logic [DATA_W-1:0] read_data;
  logic              write_en, read_en, busy, done, err;
  logic [DATA_W-1:0] write_data;
  logic [CNT_W-1:0]  wr_count, rd_count, mismatch_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_traffic_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .burst_len(burst_len),
    .full(full), .empty(empty), .read_data(read_data),
    .write_en(write_en), .write_data(write_data), .read_en(read_en),
    .busy(busy), .done(done), .err(err),
    .wr_count(wr_count), .rd_count(rd_count), .mismatch_count(mismatch_count)
  );

  // 4-deep FIFO model; flags can be forced conservative and one data value can be swapped on readout.
  logic [DATA_W-1:0] mem [4];
  logic [1:0]        wp, rp;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] rdata;
  logic              force_full = 1'b0, force_empty = 1'b0;
  logic              corrupt_en = 1'b0;
  logic [DATA_W-1:0] corrupt_from = '0, corrupt_to = '0;

  assign full      = (cnt == 3'd4) || force_full;
  assign empty     = (cnt == 3'd0) || force_empty;
  assign read_data = rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0; rp <= '0; cnt <= '0; rdata <= '0;
    end else begin
      if (write_en) begin
        mem[wp] <= write_data;
        wp <= wp + 2'd1;
      end
      if (read_en) begin
        rdata <= (corrupt_en && mem[rp] == corrupt_from) ? corrupt_to : mem[rp];
        rp <= rp + 2'd1;
      end
      cnt <= cnt + {2'b0, write_en} - {2'b0, read_en};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string t);
    check({t, "_write_en"}, write_en, 0);
    check({t, "_read_en"}, read_en, 0);
    check({t, "_write_data"}, write_data, 0);
    check({t, "_busy"}, busy, 0);
    check({t, "_done"}, done, 0);
    check({t, "_err"}, err, 0);
    check({t, "_wr_count"}, wr_count, 0);
    check({t, "_rd_count"}, rd_count, 0);
    check({t, "_mismatch_count"}, mismatch_count, 0);
  endtask

  // One complete run. hole >= 0 forces empty for 5 cycles from that cycle; poke >= 0 pulses start on that cycle.
  task automatic run(input logic [1:0] m, input int len, input bit stalls, input int hole, input int poke);
    int exp_wr, n_rd, dones, cyc, first_wr, last_wr, mm;
    bit fd, in_hole;
    fd = (m == 2'd0) || (m == 2'd3);
    mm = 0;
    if (corrupt_en)
      for (int i = 0; i < len; i++) if ((i % 16) == int'(corrupt_from)) mm++;

    @(posedge clk); #1;
    mode = m; burst_len = CNT_W'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, len != 0);
    check("err_cleared", err, 0);
    check("mm_cleared", mismatch_count, 0);
    check("wr_count_cleared", wr_count, 0);
    check("rd_count_cleared", rd_count, 0);

    exp_wr = 0; n_rd = 0; dones = 0; cyc = 0; first_wr = -1; last_wr = -1;
    while (dones == 0 && cyc < 600) begin
      in_hole     = (hole >= 0) && (cyc >= hole) && (cyc < hole + 5);
      start       = (cyc == poke);
      force_full  = stalls && ($urandom_range(0, 2) == 0);
      force_empty = (stalls && ($urandom_range(0, 2) == 0)) || in_hole;
      #1;
      if (in_hole) begin
        check("hold_no_read", read_en, 0);
        check("hold_no_write", write_en, 0);
      end
      if (write_en) begin
        check("write_data", write_data, exp_wr % 16);
        check("write_vs_full", full, 0);
        if (m == 2'd2) check("alt_write_order", exp_wr - n_rd, 0);
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        exp_wr++;
      end
      if (read_en) begin
        check("read_vs_empty", empty, 0);
        if (fd) check("drain_after_fill", exp_wr, len);
        if (m == 2'd2) check("alt_read_order", exp_wr - n_rd, 1);
        n_rd++;
      end
      if (done) dones++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; force_full = 1'b0; force_empty = 1'b0;

    check("done_seen_once", dones, 1);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("wr_count", wr_count, len);
    check("rd_count", rd_count, len);
    check("writes_issued", exp_wr, len);
    check("reads_issued", n_rd, len);
    check("mismatch_count", mismatch_count, mm);
    check("err", err, mm != 0);
    if (!stalls && len > 0) check("first_write_cycle", first_wr, 0);
    if (fd && !stalls && len > 0) check("fill_contiguous", last_wr - first_wr, len - 1);
  endtask

  initial begin
    logic [1:0] rm;
    int rlen, n_wr, cyc;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    // Directed runs: fill/drain, stream with wrap, alternate with an empty hole.
    run(2'd0, 4, 1'b0, -1, -1);
    run(2'd1, 20, 1'b0, -1, 3);
    run(2'd2, 3, 1'b0, 3, -1);

    corrupt_en = 1'b1; corrupt_from = 4'd1; corrupt_to = 4'd2;
    run(2'd0, 4, 1'b0, -1, -1);
    corrupt_en = 1'b0;
    run(2'd3, 4, 1'b0, -1, -1);

    run(2'd1, 0, 1'b0, -1, 0);

    // Reset during STREAM once seven writes are accepted.
    @(posedge clk); #1;
    mode = 2'd1; burst_len = CNT_W'(20); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_wr = 0; cyc = 0;
    while (n_wr < 7 && cyc < 200) begin
      #1;
      if (write_en) n_wr++;
      @(posedge clk); #1;
      cyc++;
    end
    check("writes_before_reset", wr_count, 7);
    rst = 1'b1;
    #1;
    check_reset_vals("async_reset");
    repeat (3) begin
      @(posedge clk); #1;
      check("no_done_in_reset", done, 0);
    end
    rst = 1'b0;
    run(2'd1, 6, 1'b0, -1, -1);

    // Randomized runs; fill/drain kept within the FIFO depth.
    for (int r = 0; r < 10; r++) begin
      rm   = 2'($urandom_range(0, 3));
      rlen = (rm == 2'd1 || rm == 2'd2) ? int'($urandom_range(1, 40)) : int'($urandom_range(0, 4));
      corrupt_en   = ($urandom_range(0, 2) == 0);
      corrupt_from = 4'($urandom_range(0, 15));
      corrupt_to   = corrupt_from ^ 4'($urandom_range(1, 15));
      run(rm, rlen, 1'($urandom_range(0, 1)), -1, -1);
    end
    corrupt_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_traffic_gen.md
# fifo_traffic_gen

Synthesizable traffic driver and in-order checker for the 4-deep x 4-bit synchronous FIFO. It issues a programmed number of writes with a counting data pattern and reads the same number back. It compares every returned word against the expected sequence and reports done, error and transfer counts. It drives the FIFO's write/read side while the passive integrity scoreboard observes the same interface.

## Interface
Parameters:
- DATA_W, 4, FIFO data width
- CNT_W, 8, width of burst length and all counters

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a run; ignored unless IDLE
- mode  in  2  0 FILL_DRAIN, 1 STREAM, 2 ALTERNATE, 3 treated as FILL_DRAIN
- burst_len  in  CNT_W  number of words to write and to read; sampled on accepted start
- full  in  1  FIFO full flag
- empty  in  1  FIFO empty flag
- read_data  in  DATA_W  FIFO read data, valid the cycle after an accepted read
- write_en  out  1  FIFO write request
- write_data  out  DATA_W  FIFO write data
- read_en  out  1  FIFO read request
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  one-cycle pulse at end of run
- err  out  1  sticky mismatch flag, cleared on accepted start
- wr_count  out  CNT_W  accepted writes this run
- rd_count  out  CNT_W  compared reads this run
- mismatch_count  out  CNT_W  mismatches this run, saturating at all-ones

## Operation
- Accepted write is write_en. Accepted read is read_en. The flag gating below guarantees neither is issued against a blocking flag.
- write_en = wr_phase && !full && (wr_count != len), combinational.
- read_en = rd_phase && !empty && (rd_issued != len), combinational.
- write_data = wr_seq[DATA_W-1:0]. wr_seq resets to 0 on accepted start and increments by 1 per accepted write, wrapping modulo 2^DATA_W.
- Read check: an accepted read sets rd_pend the next cycle. While rd_pend is high, read_data is compared with exp_seq[DATA_W-1:0], exp_seq increments, and rd_count increments.
- On mismatch, err is set and mismatch_count increments, saturating.
- States:
  - IDLE: start goes to WRITE for modes 0 and 3, STREAM for mode 1, ALT_W for mode 2. Accepted start latches len = burst_len and clears all counters, sequences and err. If burst_len == 0, start goes directly to DONE.
  - WRITE (wr_phase): goes to READ when wr_count reaches len.
  - READ (rd_phase): goes to DONE when rd_count reaches len, i.e. after the last compare.
  - STREAM (wr_phase and rd_phase together): goes to DONE when wr_count == len and rd_count == len.
  - ALT_W (wr_phase): after one accepted write, goes to ALT_R.
  - ALT_R (rd_phase): after one accepted read, goes to ALT_W. Goes to DONE when rd_count == len.
  - DONE: done = 1 for one cycle, busy = 0, then IDLE. Counters and err hold until the next accepted start.
- FILL_DRAIN with len > 4 stalls in WRITE while the FIFO is full. This is a legal hang. The bench must not use it with a non-draining FIFO.
- Simultaneous write and read in STREAM are both issued when the flags allow.

## Timing
- Reset values: write_en 0, read_en 0, write_data 0, busy 0, done 0, err 0, all counters 0, state IDLE.
- Reset mid-run aborts immediately to these values. No done pulse is produced.
- First write_en can assert in the cycle after accepted start.
- Compare latency is 1 cycle after the accepted read. rd_count updates on the edge ending the compare cycle.
- In the best case, done asserts 1 cycle after the final compare edge.
- start while busy or during DONE has no effect.
- All counters are CNT_W wide. len is at most 2^CNT_W-1, so wr_count and rd_count never wrap.

## Test plan
- FILL_DRAIN, len 4, correct FIFO:
  - writes of data 0,1,2,3 on 4 consecutive cycles, then 4 reads.
  - done exactly once; wr_count 4, rd_count 4, err 0, mismatch_count 0.
- STREAM, len 20:
  - write_data wraps 15 to 0.
  - all 20 compares pass; done once; wr_count 20, rd_count 20.
- ALTERNATE, len 3, empty forced high for 5 cycles mid-run:
  - read_en stays 0 while empty is high and the block holds in ALT_R.
  - run resumes and finishes with rd_count 3, err 0.
- FILL_DRAIN, len 4, FIFO returns 2 in place of the expected 1:
  - err 1, mismatch_count 1 at done.
  - the next start clears err to 0.
- burst_len 0, and start pulsed while busy:
  - len 0 gives done the cycle after start with all counts 0 and no write_en or read_en.
  - the extra start changes nothing.
- rst asserted during STREAM after 7 writes:
  - all outputs return to their reset values asynchronously.
  - no done pulse; the next start begins again at data 0.
